// File: rtl/uart_rx_fifo_gen2.sv
// rtl/uart_rx_fifo_gen2.sv - UART RX receive FIFO with trigger/overrun/flush flags
// Optional character-timeout interrupt enabled by `UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo_gen2 #(
  parameter int DATA_W        = 11,
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_TICKS = 64,
  localparam int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CNT_W-1:0]  trig_level,
  input  logic              tick,
  input  logic              overrun_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [CNT_W-1:0]  count,
  output logic              trig_irq,
  output logic              overrun,
  output logic              timeout_irq
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              empty_w, full_w;
  logic              do_push, do_pop, drop;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CNT_W'(DEPTH));

  // At full, a simultaneous pop frees the slot, so the push is accepted.
  always_comb begin
    do_pop    = pop  & ~flush & ~empty_w;
    do_push   = push & ~flush & (~full_w | pop);
    drop      = push & ~flush & full_w & ~pop;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
    if (drop)             overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out   = empty_w ? '0 : mem_q[rd_ptr_q];
  assign fifo_empty = empty_w;
  assign fifo_full  = full_w;
  assign count      = count_q;
  assign overrun    = overrun_q;
  assign trig_irq   = (trig_level != '0) && (count_q >= trig_level);

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_TICKS);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (flush || push || pop || empty_w) to_cnt_d = '0;
    else if (tick && to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end

  assign timeout_irq = (to_cnt_q == TO_MAX) && !empty_w;
`else
  logic unused_timeout;
  assign unused_timeout = tick | (TIMEOUT_TICKS < 1);
  assign timeout_irq    = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo_gen2.md
# uart_rx_fifo_gen2

Parametrised receive FIFO for the UART RX path, sitting between the RX deserialiser (push side) and the register/APB read interface (pop side). It generalises data width and depth, and adds several features:
- programmable trigger-level interrupt
- sticky overrun flag
- synchronous flush
- defined behaviour for simultaneous push/pop at full and empty
- optional character-timeout interrupt

## Interface
- DATA_W, 11, entry width (8 data bits + 3 status bits in the UART use)
- DEPTH, 16, number of entries; power of two, ≥ 2
- TIMEOUT_TICKS, 64, `tick` pulses of inactivity before `timeout_irq`; ≥ 1
- CNT_W (localparam), $clog2(DEPTH)+1, width of `count`/`trig_level`
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- push  in  1  write `data_in` this cycle
- pop  in  1  consume head entry this cycle
- flush  in  1  synchronous clear of contents
- data_in  in  DATA_W  write data
- trig_level  in  CNT_W  interrupt threshold; 0 disables `trig_irq`
- tick  in  1  timeout time-base strobe (e.g. one per character time)
- overrun_clr  in  1  clears `overrun`
- data_out  out  DATA_W  head entry, first-word fall-through
- fifo_empty  out  1  count == 0
- fifo_full  out  1  count == DEPTH
- count  out  CNT_W  current occupancy, 0..DEPTH
- trig_irq  out  1  count ≥ trig_level and trig_level ≠ 0
- overrun  out  1  sticky: a push was dropped
- timeout_irq  out  1  character-timeout interrupt

## Operation
- Storage: DEPTH × DATA_W array.
- Pointers: `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits, wrapping modulo DEPTH naturally.
- `count` is a separate registered counter.
- `data_out` = mem[rd_ptr] when non-empty; forced to 0 when empty.
- Storage itself is not reset.
- Priority per cycle: flush > push/pop. Flush sets both pointers and `count` to 0; push and pop in the same cycle are ignored. Flush leaves `overrun` unchanged.
- Push only, not full: write mem[wr_ptr], wr_ptr+1, count+1.
- Push only, full: data dropped, pointers and count unchanged, `overrun` set.
- Pop only, not empty: rd_ptr+1, count−1.
- Pop only, empty: ignored, no state change.
- Push+pop, 0 < count < DEPTH: both performed, count unchanged.
- Push+pop, full: both performed (the pop frees the slot), count stays DEPTH, no overrun.
- Push+pop, empty: push performed, pop ignored, count becomes 1.
- `overrun`: set has priority over `overrun_clr` in the same cycle.
- `trig_irq`, `fifo_empty`, `fifo_full`: combinational decodes of registered `count`/`trig_level`.
- If trig_level > DEPTH, `trig_irq` never asserts.

## Timing
- Reset values:
  - count 0, pointers 0
  - fifo_empty 1, fifo_full 0
  - data_out 0
  - trig_irq 0, overrun 0, timeout_irq 0
  - timeout counter 0
- Write-to-read latency is 1 cycle: data pushed at edge N appears on `data_out` and in `count` after edge N, so it can be popped at edge N+1.
- Flags follow `count` with no additional delay.
- Reset asserted mid-operation clears all state immediately (asynchronous) regardless of push/pop/flush.

## Configuration
- Macro: `UART_RX_FIFO_TIMEOUT_EN`.
- Defined: a timeout counter (width $clog2(TIMEOUT_TICKS+1)) runs as follows:
  - Increments on `tick` while the FIFO is non-empty and neither push nor pop occurs that cycle.
  - Cleared on push, pop, flush, or when empty.
  - Saturates at TIMEOUT_TICKS.
  - `timeout_irq` is 1 while counter == TIMEOUT_TICKS and the FIFO is non-empty.
  - The counter clears on the cycle after the next push, pop or flush.
- Undefined:
  - No counter logic is built.
  - `timeout_irq` is tied to 0.
  - `tick` and TIMEOUT_TICKS are ignored.
  - The port list is unchanged.

## Test plan
- Reset, then push 0x7A1 once → after the edge: count=1, fifo_empty=0, data_out=0x7A1. Pop → count=0, data_out=0.
- DEPTH=16: push 0..15 → fifo_full=1. Push 0x3FF → overrun=1, count=16. Pop 16× → data 0..15 in order, empty. Pulse overrun_clr → overrun=0.
- Wrap-around: 40 interleaved push/pop pairs at count=5 → count stays 5, data order preserved across pointer wrap.
- Simultaneous events:
  - push+pop when full → count 16, no overrun, head advances.
  - push+pop when empty → count 1.
  - flush+push → count 0.
- trig_level=4:
  - trig_irq rises on the cycle count reaches 4 and falls when it drops to 3.
  - trig_level=0 → never asserts.
  - Assert rstn low mid-burst → all outputs at reset values at once.
- With `UART_RX_FIFO_TIMEOUT_EN`, TIMEOUT_TICKS=4, one entry held:
  - 4 tick pulses → timeout_irq=1.
  - Pop → 0 the next cycle.
  - Without the macro → always 0.
